// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. It answers the Fetcher with a
// one-cycle ready/data pulse. On a miss it refills the whole line, one word at
// a time, over the mc word port. A flush squashes the pending response, but a
// refill that has already started always runs to completion.
module icache #(
  parameter int INDEX_BITS     = 6,
  parameter int LINE_WORDS_LOG = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        rob_clear,
  output logic        mc_valid,
  output logic [31:0] mc_addr,
  input  logic        mc_ready,
  input  logic [31:0] mc_data
);

  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_WORDS = 1 << LINE_WORDS_LOG;
  localparam int IDX_LO     = 2 + LINE_WORDS_LOG;
  localparam int TAG_LO     = IDX_LO + INDEX_BITS;
  localparam int TAG_BITS   = 32 - TAG_LO;
  localparam logic [LINE_WORDS_LOG-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL} state_t;

  state_t                    r_state, w_state_next;
  logic [LINE_WORDS_LOG-1:0] r_cnt, w_cnt_next;
  logic [31:0]               r_req_addr, w_req_addr_next;
  logic [LINES-1:0]          r_valid;
  logic [TAG_BITS-1:0]       r_tag  [LINES];
  logic [31:0]               r_data [LINES*LINE_WORDS];

  logic [LINE_WORDS_LOG-1:0] w_off;
  logic [INDEX_BITS-1:0]     w_idx;
  logic [TAG_BITS-1:0]       w_tag;
  logic                      w_hit;
  logic                      w_same;
  logic [31:0]               w_word;
  logic                      w_valid_clr;
  logic                      w_valid_set;
  logic                      w_data_we;
  logic                      w_unused;

  // Fields of the captured request; all lookups and refills work on r_req_addr.
  assign w_off    = r_req_addr[IDX_LO-1:2];
  assign w_idx    = r_req_addr[TAG_LO-1:IDX_LO];
  assign w_tag    = r_req_addr[31:TAG_LO];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_same   = (if_addr[31:2] == r_req_addr[31:2]);
  assign w_word   = r_data[{w_idx, w_off}];
  assign if_data  = if_ready ? w_word : 32'd0;
  // The byte-offset bits are never used for lookup.
  assign w_unused = ^{if_addr[1:0], r_req_addr[1:0]};

  // Next-state, register updates and handshake outputs of the lookup/refill FSM.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_req_addr_next = r_req_addr;
    w_valid_clr     = 1'b0;
    w_valid_set     = 1'b0;
    w_data_we       = 1'b0;
    if_ready        = 1'b0;
    mc_valid        = 1'b0;
    mc_addr         = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (if_valid && !rob_clear) begin
          w_req_addr_next = if_addr;
          w_state_next    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (rob_clear) begin
          w_state_next = S_IDLE;
        end else if (!if_valid || !w_same) begin
          // The Fetcher moved on; drop the response silently.
          w_state_next = S_IDLE;
        end else if (w_hit) begin
          if_ready     = rdy_in && !rst_in;
          w_state_next = S_IDLE;
        end else begin
          w_valid_clr  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mc_valid = 1'b1;
        mc_addr  = {w_tag, w_idx, r_cnt, 2'b00};
        if (mc_ready) begin
          w_data_we  = 1'b1;
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == LAST_WORD) begin
            w_valid_set  = 1'b1;
            w_state_next = S_LOOKUP;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset abandons any refill immediately.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_next;
    end
  end

  // Word counter and captured request address.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt      <= '0;
      r_req_addr <= 32'd0;
    end else if (rdy_in) begin
      r_cnt      <= w_cnt_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  // Per-line valid bits: cleared when a refill starts, set when it finishes.
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_valid[gi] <= 1'b0;
        end else if (rdy_in && (w_idx == gi)) begin
          if (w_valid_clr) begin
            r_valid[gi] <= 1'b0;
          end else if (w_valid_set) begin
            r_valid[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // Tag and data storage; not reset, guarded by the valid bits instead.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in) begin
      if (w_data_we) begin
        r_data[{w_idx, r_cnt}] <= mc_data;
      end
      if (w_valid_set) begin
        r_tag[w_idx] <= w_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomised bench for icache: a responder plays the memory controller and a
// line-level reference model predicts hits, misses and refill addresses.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ready;
  logic [31:0] if_data;
  logic        rob_clear = 1'b0;
  logic        mc_valid;
  logic [31:0] mc_addr;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_data = 32'd0;

  int checks = 0;
  int errors = 0;
  int mc_cnt = 0;
  bit mon_en = 1'b0;

  // Reference model: which memory line each cache index holds.
  bit          mv [64];
  logic [21:0] mt [64];
  logic [31:0] exp_mc [$];

  icache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .rob_clear(rob_clear),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_ready(mc_ready), .mc_data(mc_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Predict the outcome for address a; a miss queues the line's word addresses.
  task automatic predict(input logic [31:0] a, output bit hit);
    int idx;
    idx = int'(a[9:4]);
    hit = mv[idx] && (mt[idx] == a[31:10]);
    if (!hit) begin
      for (int w = 0; w < 4; w++) exp_mc.push_back({a[31:4], 4'b0000} + 32'(4 * w));
      mv[idx] = 1'b1;
      mt[idx] = a[31:10];
    end
  endtask

  task automatic start_req(input logic [31:0] a, output bit hit);
    predict(a, hit);
    if_addr  = a;
    if_valid = 1'b1;
  endtask

  // Wait for the response to a; lat_exp < 0 skips the latency check.
  task automatic wait_resp(input logic [31:0] a, input int lat_exp);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk_in);
      n++;
      if (if_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      check("timeout", 32'd1, 32'd0);
    end else begin
      if (lat_exp >= 0) check("latency", 32'(n), 32'(lat_exp));
      check("data", if_data, mem_word({a[31:2], 2'b00}));
      check("refill_done", 32'(exp_mc.size()), 32'd0);
      $display("fetch addr=%h data=%h cycles=%0d", a, if_data, n);
    end
    @(posedge clk_in); #1;
    if_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    bit hit;
    start_req(a, hit);
    wait_resp(a, hit ? 2 : -1);
  endtask

  task automatic wait_mc(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(posedge clk_in); #1;
      if (mc_cnt >= target) ok = 1'b1;
    end
    if (!ok) check("mc_timeout", 32'd1, 32'd0);
  endtask

  // Memory-controller responder: one-cycle ready pulses after a random delay.
  initial begin
    int wt;
    wt = 0;
    forever begin
      @(negedge clk_in);
      if (mc_ready) begin
        mc_ready = 1'b0;
        mc_data  = $urandom;
      end else if (mc_valid === 1'b1) begin
        if (wt == 0) begin
          mc_ready = 1'b1;
          mc_data  = mem_word(mc_addr);
          wt = $urandom_range(0, 2);
        end else begin
          wt--;
        end
      end
    end
  end

  // Every accepted mc word must be the next one the model expects.
  always @(posedge clk_in) begin
    if (mon_en && rdy_in && !rst_in && mc_valid && mc_ready) begin
      if (exp_mc.size() == 0) check("mc_extra", mc_addr, 32'hFFFF_FFFF);
      else check("mc_addr", mc_addr, exp_mc.pop_front());
      mc_cnt++;
    end
  end

  // Output rules that hold on every cycle.
  always @(negedge clk_in) begin
    if (mon_en) begin
      check("ready_gate", {31'd0, if_ready & (~if_valid | rob_clear | ~rdy_in)}, 32'd0);
      if (if_ready === 1'b1) check("ready_data", if_data, mem_word({if_addr[31:2], 2'b00}));
      else check("data_idle", if_data, 32'd0);
      if (mc_valid !== 1'b1) check("mc_addr_idle", mc_addr, 32'd0);
    end
  end

  initial begin
    bit hit;
    int base;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mc_valid", {31'd0, mc_valid}, 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    mon_en = 1'b1;

    // Cold miss, hit, conflict miss, re-miss
    fetch(32'h0000_0000);
    fetch(32'h0000_0008);
    fetch(32'h0000_0400);
    fetch(32'h0000_0000);

    // Flush during word 2 of a refill while the Fetcher moves to 0x100
    base = mc_cnt;
    start_req(32'h0000_0020, hit);
    wait_mc(base + 2);
    rob_clear = 1'b1;
    if_addr   = 32'h0000_0100;
    predict(32'h0000_0100, hit);
    @(posedge clk_in); #1;
    rob_clear = 1'b0;
    wait_resp(32'h0000_0100, -1);
    fetch(32'h0000_0024);

    // Stale address in LOOKUP
    start_req(32'h0000_0024, hit);
    @(posedge clk_in); #1;
    if_addr = 32'h0000_0028;
    predict(32'h0000_0028, hit);
    @(negedge clk_in);
    check("stale_ready", {31'd0, if_ready}, 32'd0);
    wait_resp(32'h0000_0028, 2);

    // Flush in LOOKUP
    start_req(32'h0000_002C, hit);
    @(posedge clk_in); #1;
    rob_clear = 1'b1;
    @(negedge clk_in);
    check("flush_ready", {31'd0, if_ready}, 32'd0);
    @(posedge clk_in); #1;
    rob_clear = 1'b0;
    wait_resp(32'h0000_002C, 2);

    // Global stall for 3 cycles after the first refill word
    base = mc_cnt;
    start_req(32'h0000_0300, hit);
    wait_mc(base + 1);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      check("stall_ready", {31'd0, if_ready}, 32'd0);
      check("stall_mc_valid", {31'd0, mc_valid}, 32'd1);
      check("stall_mc_addr", mc_addr, 32'h0000_0304);
      check("stall_mc_cnt", 32'(mc_cnt), 32'(base + 1));
    end
    @(posedge clk_in); #1;
    rdy_in = 1'b1;
    wait_resp(32'h0000_0300, -1);

    // Reset in the middle of a refill
    base = mc_cnt;
    start_req(32'h0000_0500, hit);
    wait_mc(base + 2);
    rst_in   = 1'b1;
    if_valid = 1'b0;
    exp_mc.delete();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_refill_mc_valid", {31'd0, mc_valid}, 32'd0);
    @(posedge clk_in); #1;
    fetch(32'h0000_0500);
    fetch(32'h0000_0504);
    fetch(32'h0000_0000);

    // Random traffic over a small pool of lines to mix hits and conflicts
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_in); #1;
      end
      a = {20'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      fetch(a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
